// File: rtl/ibex_register_file_mp_if.sv
// Bundled read/write/clear signals of the multi-port register file.
// master = core side driving addresses and write data, slave = the register file.
interface ibex_register_file_mp_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned NumRead   = 2,
  parameter int unsigned NumWrite  = 2
);
  logic [NumRead*AddrWidth-1:0]  raddr_i;
  logic [NumRead*DataWidth-1:0]  rdata_o;
  logic [NumWrite*AddrWidth-1:0] waddr_i;
  logic [NumWrite*DataWidth-1:0] wdata_i;
  logic [NumWrite-1:0]           we_i;
  logic                          clr_req_i;
  logic                          clr_busy_o;
  logic                          clr_done_o;
  logic                          err_o;
  logic                          perr_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, clr_req_i,
    input  rdata_o, clr_busy_o, clr_done_o, err_o, perr_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, clr_req_i,
    output rdata_o, clr_busy_o, clr_done_o, err_o, perr_o
  );
endinterface

// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file with NumRead read / NumWrite write ports, bypass, collision flag
// and a sequential bulk-clear engine. Define IBEX_RF_PARITY_EN to add per-word even parity.
module ibex_register_file_mp #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          AddrWidth   = 5,
  parameter int unsigned          NumRead     = 2,
  parameter int unsigned          NumWrite    = 2,
  parameter bit                   WriteBypass = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ibex_register_file_mp_if.slave rf
);

  localparam int unsigned NumWords = 2 ** AddrWidth;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } clr_state_e;

  clr_state_e           state_reg;
  logic [AddrWidth-1:0] cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;
  logic                 collision_next;

  logic [AddrWidth-1:0] waddr [NumWrite];
  logic [DataWidth-1:0] wdata [NumWrite];
  logic [NumWrite-1:0]  wvalid;
  logic [DataWidth-1:0] rf_view [NumWords];

  // A write is accepted only for a nonzero address while the clear engine is idle.
  for (genvar gi = 0; gi < NumWrite; gi++) begin : gen_wport
    assign waddr[gi]  = rf.waddr_i[gi*AddrWidth +: AddrWidth];
    assign wdata[gi]  = rf.wdata_i[gi*DataWidth +: DataWidth];
    assign wvalid[gi] = rf.we_i[gi] & (waddr[gi] != '0) & ~busy_reg;
  end

  always_comb begin
    collision_next = 1'b0;
    for (int unsigned i = 0; i < NumWrite; i++) begin
      for (int unsigned j = i + 1; j < NumWrite; j++) begin
        if (wvalid[i] && wvalid[j] && (waddr[i] == waddr[j])) begin
          collision_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= AddrWidth'(1);
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg  <= collision_next;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rf.clr_req_i) begin
            state_reg <= ST_CLEAR;
            busy_reg  <= 1'b1;
            cnt_reg   <= AddrWidth'(1);
          end
        end
        ST_CLEAR: begin
          // The last word reloads 1 instead of wrapping, so word 0 is never targeted.
          if (&cnt_reg) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            cnt_reg   <= AddrWidth'(1);
          end else begin
            cnt_reg <= cnt_reg + AddrWidth'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_view[0] = WordZeroVal;

`ifdef IBEX_RF_PARITY_EN
  logic                par_view [NumWords];
  logic [NumRead-1:0]  perr_port;
  assign par_view[0] = ^WordZeroVal;
`endif

  for (genvar gi = 1; gi < NumWords; gi++) begin : gen_word
    logic [DataWidth-1:0] word_reg;
    logic [DataWidth-1:0] word_next;
    logic                 word_we;

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_comb begin
      word_we   = 1'b0;
      word_next = word_reg;
      for (int unsigned j = 0; j < NumWrite; j++) begin
        if (wvalid[j] && (waddr[j] == AddrWidth'(gi))) begin
          word_we   = 1'b1;
          word_next = wdata[j];
        end
      end
      if (busy_reg && (cnt_reg == AddrWidth'(gi))) begin
        word_we   = 1'b1;
        word_next = WordZeroVal;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        word_reg <= WordZeroVal;
      end else if (word_we) begin
        word_reg <= word_next;
      end
    end

    assign rf_view[gi] = word_reg;

`ifdef IBEX_RF_PARITY_EN
    logic par_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        par_reg <= ^WordZeroVal;
      end else if (word_we) begin
        par_reg <= ^word_next;
      end
    end
    assign par_view[gi] = par_reg;
`endif
  end

  for (genvar gi = 0; gi < NumRead; gi++) begin : gen_read
    logic [AddrWidth-1:0] raddr;
    logic [DataWidth-1:0] rdata;
`ifdef IBEX_RF_PARITY_EN
    logic                 bypassed;
`endif

    assign raddr = rf.raddr_i[gi*AddrWidth +: AddrWidth];

    // wvalid already excludes address 0 and busy cycles, so bypass never hits either.
    always_comb begin
      rdata = rf_view[raddr];
`ifdef IBEX_RF_PARITY_EN
      bypassed = 1'b0;
`endif
      if (WriteBypass) begin
        for (int unsigned j = 0; j < NumWrite; j++) begin
          if (wvalid[j] && (waddr[j] == raddr)) begin
            rdata = wdata[j];
`ifdef IBEX_RF_PARITY_EN
            bypassed = 1'b1;
`endif
          end
        end
      end
    end

    assign rf.rdata_o[gi*DataWidth +: DataWidth] = rdata;

`ifdef IBEX_RF_PARITY_EN
    assign perr_port[gi] = ~bypassed & (raddr != '0) &
                           ((^rf_view[raddr]) != par_view[raddr]);
`endif
  end

`ifdef IBEX_RF_PARITY_EN
  assign rf.perr_o = |perr_port;
`else
  assign rf.perr_o = 1'b0;
`endif

  assign rf.clr_busy_o = busy_reg;
  assign rf.clr_done_o = done_reg;
  assign rf.err_o      = err_reg;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Scoreboard bench: stimulus queues expected values tagged with a cycle, a negedge monitor checks them.
// A second instance with WriteBypass = 0 shares the inputs to contrast bypass behaviour.
module tb_ibex_register_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_register_file_mp_if #(.DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .NumWrite(NW)) rf ();
  ibex_register_file_mp_if #(.DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .NumWrite(NW)) rf_nb ();

  assign rf_nb.raddr_i   = rf.raddr_i;
  assign rf_nb.waddr_i   = rf.waddr_i;
  assign rf_nb.wdata_i   = rf.wdata_i;
  assign rf_nb.we_i      = rf.we_i;
  assign rf_nb.clr_req_i = rf.clr_req_i;

  ibex_register_file_mp #(
    .DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .NumWrite(NW), .WriteBypass(1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .rf    (rf.slave)
  );

  ibex_register_file_mp #(
    .DataWidth(DW), .AddrWidth(AW), .NumRead(NR), .NumWrite(NW), .WriteBypass(1'b0)
  ) dut_nb (
    .clk_i (clk),
    .rst_ni(rst_n),
    .rf    (rf_nb.slave)
  );

  typedef enum int {S_RD0, S_RD1, S_ERR, S_BUSY, S_DONE, S_PERR, S_RD0_NB} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(sig_e s);
    case (s)
      S_RD0:    return rf.rdata_o[31:0];
      S_RD1:    return rf.rdata_o[63:32];
      S_ERR:    return {31'd0, rf.err_o};
      S_BUSY:   return {31'd0, rf.clr_busy_o};
      S_DONE:   return {31'd0, rf.clr_done_o};
      S_PERR:   return {31'd0, rf.perr_o};
      default:  return rf_nb.rdata_o[31:0];
    endcase
  endfunction

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].at <= cyc) begin
        tests++;
        if (exp_q[i].at < cyc) begin
          fails++;
          $display("FAIL %s: not sampled in cycle %0d (now %0d)", exp_q[i].name, exp_q[i].at, cyc);
        end else if (actual(exp_q[i].sig) !== exp_q[i].val) begin
          fails++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", exp_q[i].name,
                   actual(exp_q[i].sig), exp_q[i].val, cyc);
        end else begin
          $display("[TB] ok %s = %h (cycle %0d)", exp_q[i].name, exp_q[i].val, cyc);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf.we_i      = '0;
    rf.clr_req_i = 1'b0;
  endtask

  task automatic wr(int p, int a, logic [31:0] d);
    rf.we_i[p]                = 1'b1;
    rf.waddr_i[p*AW +: AW]    = AW'(a);
    rf.wdata_i[p*DW +: DW]    = d;
  endtask

  task automatic rd(int p, int a);
    rf.raddr_i[p*AW +: AW] = AW'(a);
  endtask

  task automatic chk(string n, sig_e s, logic [31:0] v, int dly);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    e.at   = cyc + dly;
    exp_q.push_back(e);
  endtask

  initial begin
    rf.raddr_i = '0;
    rf.waddr_i = '0;
    rf.wdata_i = '0;
    idle();
    rst_n = 1'b0;
    tick();
    rd(0, 5);
    chk("rst_busy", S_BUSY, 32'd0, 0);
    chk("rst_done", S_DONE, 32'd0, 0);
    chk("rst_err",  S_ERR,  32'd0, 0);
    chk("rst_perr", S_PERR, 32'd0, 0);
    chk("rst_x5",   S_RD0,  32'd0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Plain write then read, plus x0 read.
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle(); rd(0, 5); rd(1, 0);
    chk("x5_read", S_RD0, 32'hDEADBEEF, 0);
    chk("x0_read", S_RD1, 32'd0, 0);
    chk("no_err",  S_ERR, 32'd0, 0);
    tick();

    // Collision: port 1 wins, err pulses for one cycle.
    wr(0, 7, 32'h1111); wr(1, 7, 32'h2222);
    tick();
    idle(); rd(0, 7);
    chk("x7_collide", S_RD0, 32'h2222, 0);
    chk("err_pulse",  S_ERR, 32'd1, 0);
    tick();
    chk("err_clear",  S_ERR, 32'd0, 0);
    tick();

    // Same-cycle bypass vs stored-only read.
    wr(0, 9, 32'hA5A5A5A5); rd(0, 9);
    chk("bypass_x9",    S_RD0,    32'hA5A5A5A5, 0);
    chk("nobypass_x9",  S_RD0_NB, 32'd0, 0);
    tick();
    idle(); rd(0, 9);
    chk("nb_x9_stored", S_RD0_NB, 32'hA5A5A5A5, 0);
    tick();
    wr(0, 11, 32'h3); wr(1, 11, 32'h4); rd(0, 11);
    chk("bypass_prio", S_RD0, 32'h4, 0);
    chk("err_x11",     S_ERR, 32'd1, 1);
    tick();
    idle();
    wr(0, 0, 32'hFFFF); rd(0, 0);
    chk("x0_no_bypass", S_RD0, 32'd0, 0);
    tick();

    // Fill x1..x31 with nonzero values.
    for (int k = 0; k < 16; k++) begin
      idle();
      wr(0, 2*k + 1, 32'hC000_0000 | (2*k + 1));
      if (2*k + 2 <= 31) wr(1, 2*k + 2, 32'hC000_0000 | (2*k + 2));
      tick();
    end
    idle(); rd(0, 1); rd(1, 31);
    chk("fill_x1",  S_RD0, 32'hC000_0001, 0);
    chk("fill_x31", S_RD1, 32'hC000_001F, 0);
    tick();

    // Bulk clear: busy 31 cycles, then one done pulse.
    rf.clr_req_i = 1'b1;
    chk("clr_busy_req",   S_BUSY, 32'd0, 0);
    chk("clr_busy_first", S_BUSY, 32'd1, 1);
    chk("clr_busy_last",  S_BUSY, 32'd1, 31);
    chk("clr_done_early", S_DONE, 32'd0, 31);
    chk("clr_busy_end",   S_BUSY, 32'd0, 32);
    chk("clr_done_pulse", S_DONE, 32'd1, 32);
    chk("clr_done_after", S_DONE, 32'd0, 33);
    tick();
    for (int i = 1; i <= 33; i++) begin
      idle();
      if (i == 5) begin
        rd(0, 2); rd(1, 20);
        chk("mid_clr_x2",  S_RD0, 32'd0, 0);
        chk("mid_clr_x20", S_RD1, 32'hC000_0014, 0);
      end
      if (i == 10) begin
        wr(0, 3, 32'h5); wr(1, 3, 32'h6); rd(0, 3);
        chk("busy_no_bypass", S_RD0, 32'd0, 0);
        chk("busy_no_err",    S_ERR, 32'd0, 1);
      end
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      idle(); rd(0, 2*k); rd(1, 2*k + 1);
      chk($sformatf("cleared_x%0d", 2*k),     S_RD0, 32'd0, 0);
      chk($sformatf("cleared_x%0d", 2*k + 1), S_RD1, 32'd0, 0);
      tick();
    end

    // Reset in the middle of a clear.
    idle(); wr(0, 20, 32'h1234); wr(1, 30, 32'h5678);
    tick();
    idle(); rd(0, 20); rd(1, 30);
    chk("pre_x20", S_RD0, 32'h1234, 0);
    chk("pre_x30", S_RD1, 32'h5678, 0);
    rf.clr_req_i = 1'b1;
    tick();
    rf.clr_req_i = 1'b0;
    repeat (8) tick();
    chk("abort_busy_before", S_BUSY, 32'd1, 0);
    tick();
    rst_n = 1'b0;
    chk("abort_busy", S_BUSY, 32'd0, 0);
    chk("abort_done", S_DONE, 32'd0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    rd(0, 20); rd(1, 30);
    chk("abort_x20",   S_RD0,  32'd0, 0);
    chk("abort_x30",   S_RD1,  32'd0, 0);
    chk("abort_idle",  S_BUSY, 32'd0, 0);
    tick();

`ifdef IBEX_RF_PARITY_EN
    idle(); wr(0, 4, 32'h1);
    tick();
    idle();
    force dut.gen_word[4].word_reg = 32'h3;
    rd(0, 4); rd(1, 0);
    chk("perr_x4", S_PERR, 32'd1, 0);
    tick();
    rd(0, 0);
    chk("perr_x0", S_PERR, 32'd0, 0);
    tick();
    release dut.gen_word[4].word_reg;
`else
    idle(); rd(0, 5); rd(1, 9);
    chk("perr_off", S_PERR, 32'd0, 0);
    tick();
`endif

    tick();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
- Flip-flop register file generalised to N read ports and M write ports, for dual-issue and multi-writeback cores.
- Register 0 is hard-wired to WordZeroVal.
- Adds optional same-cycle write-to-read bypass and write-collision detection.
- Adds a sequential bulk-clear engine that zeroes the whole file on request, for secure wipe and context reset.
- Sits in the ID stage in place of the single-write FF register file.

Parameters:
DataWidth, 32, bits per register
AddrWidth, 5, address bits; NumWords = 2**AddrWidth (4 gives RV32E)
NumRead, 2, number of read ports (1..4)
NumWrite, 2, number of write ports (1..3); higher index = higher priority
WriteBypass, 1, 1 = read returns same-cycle write data for a matching address
WordZeroVal, '0, reset/clear value and the value returned for register 0

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
raddr_i  in  NumRead*AddrWidth  packed read addresses, port k at [k*AddrWidth +: AddrWidth]
rdata_o  out  NumRead*DataWidth  packed read data, port k at [k*DataWidth +: DataWidth]
waddr_i  in  NumWrite*AddrWidth  packed write addresses
wdata_i  in  NumWrite*DataWidth  packed write data
we_i  in  NumWrite  per-port write enable
clr_req_i  in  1  bulk-clear request, level or pulse
clr_busy_o  out  1  clear engine active
clr_done_o  out  1  one-cycle pulse when clear completes
err_o  out  1  registered write-collision flag, one-cycle pulse
perr_o  out  1  read parity error (optional feature)

Behaviour:
- Reset (asynchronous, rst_ni low):
  - All registers 1..NumWords-1 load WordZeroVal.
  - Clear FSM goes to IDLE; clear counter = 1.
  - clr_busy_o = 0, clr_done_o = 0, err_o = 0, perr_o = 0.
- Register 0: no storage. Writes to address 0 are discarded; reads of address 0 return WordZeroVal.
- Write decode:
  - Port j writes register a when we_i[j] = 1, waddr_j = a, a != 0, and clr_busy_o = 0.
  - Data is visible on a plain read the next cycle.
- Write collision:
  - Two or more enabled ports targeting the same nonzero address in one cycle: the highest-index port's data is stored.
  - err_o = 1 in the following cycle, for exactly one cycle per colliding cycle.
- Read:
  - Fully combinational from raddr_i.
  - WriteBypass = 1: if an accepted write targets the read address this cycle, rdata returns that wdata; with multiple matches, the highest-index port wins.
  - Bypass never applies to address 0, and never applies while clr_busy_o = 1.
  - WriteBypass = 0: reads return stored values only.
- Clear FSM: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req_i = 1. clr_busy_o rises the next cycle, and the counter loads 1.
  - CLEAR: each cycle register[counter] <= WordZeroVal and the counter increments.
  - CLEAR -> DONE after writing NumWords-1. This takes NumWords-1 cycles in CLEAR (31 for AddrWidth = 5).
  - DONE: clr_done_o = 1 for one cycle; clr_busy_o = 0 in DONE. Next state IDLE.
  - clr_req_i is ignored in CLEAR and DONE. A request held high re-triggers from IDLE.
  - All we_i are ignored while clr_busy_o = 1; no collision is flagged in that state.
  - Reads during CLEAR return current stored values: already-cleared entries read WordZeroVal, the rest keep old data.
  - Counter width is AddrWidth; wrap from NumWords-1 ends CLEAR, and the counter never revisits 0.
- Reset mid-clear aborts immediately to IDLE with all registers at WordZeroVal.

Optional Feature:
- Macro: IBEX_RF_PARITY_EN.
- When defined:
  - Each register stores an extra even-parity bit, computed from the write data on write and set to the parity of WordZeroVal on clear/reset.
  - Every read port recomputes parity on the stored word.
  - perr_o = OR over ports of mismatch, combinational, on non-bypassed, nonzero-address reads only.
- When not defined: no parity storage and perr_o tied to 0.

Test Plan:
- Reset, then write x5 = 32'hDEADBEEF on port 0; next cycle raddr port 0 = 5 and port 1 = 0 -> rdata0 = 32'hDEADBEEF, rdata1 = 0, err_o = 0.
- Same cycle: port 0 writes x7 = 32'h1111, port 1 writes x7 = 32'h2222 -> next cycle x7 reads 32'h2222 and err_o pulses 1 for one cycle.
- WriteBypass = 1: write x9 = 32'hA5A5A5A5 while reading address 9 in the same cycle -> rdata = 32'hA5A5A5A5 that cycle. With WriteBypass = 0 -> old value 0.
- Fill x1..x31 with nonzero values, pulse clr_req_i -> clr_busy_o high for 31 cycles, then clr_done_o pulses once; all registers read 0. A write of x3 = 32'h5 during busy is dropped.
- Start a clear, assert rst_ni low at clear cycle 10 -> busy = 0 and done = 0 immediately; all registers read 0 after reset release.
- IBEX_RF_PARITY_EN defined: write x4 = 32'h1, force one stored bit flip -> reading x4 gives perr_o = 1; reading x0 gives perr_o = 0.
